// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: HI/LO multiply/divide unit opcodes, FSM states and sizing.
package mips_cpu_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;
    localparam int unsigned MULDIV_ITER  = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } muldiv_op_enum;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } muldiv_state_enum;

    // Signed variants iterate on magnitudes and get corrected in SIGN.
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration step: shift-add multiply or restoring-divide, selected by i_is_div.
module muldiv_iter
    import mips_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_operand,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    // Divide:   acc = {partial remainder, remaining dividend bits / quotient bits}, shifted left.
    always_comb begin
        w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
        w_rem  = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_ge   = (w_rem >= {1'b0, i_operand});
        w_diff = WIDTH'(w_rem - {1'b0, i_operand});
        if (i_is_div) begin
            o_acc = {(w_ge ? w_diff : w_rem[WIDTH-1:0]), i_acc[WIDTH-2:0], w_ge};
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS HI/LO multiply/divide controller with iterative datapath.
// Define MULDIV_FAST_MULT_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_ctrl
    import mips_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH,
    parameter int unsigned ITER  = MULDIV_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             cancel_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CNT_W = $clog2(ITER);

    muldiv_state_enum   r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_is_div;
    logic               r_dz;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div_zero;
    logic               r_ready;

    logic               w_accept;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_neg_acc;
    logic [WIDTH-1:0]   w_neg_hi;
    logic [WIDTH-1:0]   w_neg_lo;
`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] w_fast_prod;
`endif

    assign w_accept  = start_i & r_ready & ~cancel_i;
    assign w_sgn     = md_is_signed(op_i);
    assign w_mag_a   = (w_sgn && src_a_i[WIDTH-1]) ? ('0 - src_a_i) : src_a_i;
    assign w_mag_b   = (w_sgn && src_b_i[WIDTH-1]) ? ('0 - src_b_i) : src_b_i;
    assign w_neg_acc = '0 - r_acc;
    assign w_neg_hi  = '0 - r_acc[2*WIDTH-1:WIDTH];
    assign w_neg_lo  = '0 - r_acc[WIDTH-1:0];
`ifdef MULDIV_FAST_MULT_EN
    assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`endif

    muldiv_iter #(
        .WIDTH     (WIDTH)
    ) u_iter (
        .i_is_div  (r_is_div),
        .i_acc     (r_acc),
        .i_operand (r_b),
        .o_acc     (w_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_b        <= '0;
            r_is_div   <= 1'b0;
            r_dz       <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (op_i)
                            MD_MULT, MD_MULTU: begin
                                r_is_div <= 1'b0;
                                r_dz     <= 1'b0;
                                r_neg_q  <= w_sgn & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
                                r_neg_r  <= 1'b0;
                                r_ready  <= 1'b0;
`ifdef MULDIV_FAST_MULT_EN
                                r_acc    <= w_fast_prod;
                                r_state  <= SIGN;
`else
                                r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
                                r_b      <= w_mag_a;
                                r_cnt    <= '0;
                                r_state  <= CALC;
`endif
                            end
                            MD_DIV, MD_DIVU: begin
                                r_is_div <= 1'b1;
                                r_neg_q  <= w_sgn & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
                                r_neg_r  <= w_sgn & src_a_i[WIDTH-1];
                                r_ready  <= 1'b0;
                                // A zero divisor skips the iterations and only reports the flag.
                                if (src_b_i == '0) begin
                                    r_dz    <= 1'b1;
                                    r_state <= SIGN;
                                end else begin
                                    r_dz    <= 1'b0;
                                    r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                                    r_b     <= w_mag_b;
                                    r_cnt   <= '0;
                                    r_state <= CALC;
                                end
                            end
                            MD_MTHI: begin
                                r_hi   <= src_a_i;
                                r_done <= 1'b1;
                            end
                            MD_MTLO: begin
                                r_lo   <= src_a_i;
                                r_done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (cancel_i) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_acc <= w_step;
                        if (r_cnt == CNT_W'(ITER - 1)) begin
                            r_cnt   <= '0;
                            r_state <= SIGN;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                SIGN: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    if (!cancel_i) begin
                        r_done <= 1'b1;
                        if (r_dz) begin
                            r_div_zero <= 1'b1;
                        end else if (r_is_div) begin
                            r_lo <= r_neg_q ? w_neg_lo : r_acc[WIDTH-1:0];
                            r_hi <= r_neg_r ? w_neg_hi : r_acc[2*WIDTH-1:WIDTH];
                        end else begin
                            {r_hi, r_lo} <= r_neg_q ? w_neg_acc : r_acc;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o    = r_ready;
    assign done_o     = r_done;
    assign div_zero_o = r_div_zero;
    assign hi_o       = r_hi;
    assign lo_o       = r_lo;

endmodule
